// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - two-digit BCD to multiplexed common-anode seven-segment driver
// Optional build macro: LEADING_ZERO_BLANK_EN (dark tens digit when the captured tens is zero).
module bcd_display_mux #(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 16,
  parameter int TMR_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_done
);

  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_O = 2'd2,
    SHOW_O  = 2'd3
  } state_t;

  localparam logic [TMR_W-1:0] SHOW_LAST = TMR_W'(REFRESH_DIV - 1);
  localparam logic [TMR_W-1:0] DEAD_LAST = TMR_W'(DEAD_CYCLES - 1);
  localparam logic [6:0]       SEG_OFF   = 7'h7F;
  localparam logic [1:0]       AN_OFF    = 2'b11;

  state_t           state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [3:0]       tens_sh, ones_sh;
  logic             slot_end;
  logic             capture;
  logic [3:0]       tens_view;
  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;
  logic             frame_done_nxt;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F;
    endcase
  endfunction

  always_comb begin
    slot_end  = 1'b0;
    state_nxt = state;
    case (state)
      BLANK_T: begin
        slot_end = (timer == DEAD_LAST);
        if (slot_end) state_nxt = SHOW_T;
      end
      SHOW_T: begin
        slot_end = (timer == SHOW_LAST);
        if (slot_end) state_nxt = BLANK_O;
      end
      BLANK_O: begin
        slot_end = (timer == DEAD_LAST);
        if (slot_end) state_nxt = SHOW_O;
      end
      default: begin
        slot_end = (timer == SHOW_LAST);
        if (slot_end) state_nxt = BLANK_T;
      end
    endcase
  end

  // The tens slot is decoded from the live input on the capture edge so it matches the shadow.
  always_comb begin
    capture        = (state == BLANK_T) && slot_end;
    tens_view      = capture ? tens : tens_sh;
    seg_nxt        = SEG_OFF;
    an_nxt         = AN_OFF;
    frame_done_nxt = (state == SHOW_O) && slot_end;
    case (state_nxt)
      SHOW_T: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_view != 4'd0) begin
          seg_nxt = dec(tens_view);
          an_nxt  = 2'b10;
        end
`else
        seg_nxt = dec(tens_view);
        an_nxt  = 2'b10;
`endif
      end
      SHOW_O: begin
        seg_nxt = dec(ones_sh);
        an_nxt  = 2'b01;
      end
      default: begin
        seg_nxt = SEG_OFF;
        an_nxt  = AN_OFF;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK_T;
      timer      <= '0;
      tens_sh    <= 4'd0;
      ones_sh    <= 4'd0;
      seg_n      <= SEG_OFF;
      an_n       <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= slot_end ? '0 : timer + TMR_W'(1);
      seg_n      <= seg_nxt;
      an_n       <= an_nxt;
      frame_done <= frame_done_nxt;
      if (capture) begin
        tens_sh <= tens;
        ones_sh <= ones;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - self-checking bench for bcd_display_mux
// Honours LEADING_ZERO_BLANK_EN the same way the design does.
module tb_bcd_display_mux;

  localparam int RD    = 8;
  localparam int DC    = 2;
  localparam int FRAME = 2 * (RD + DC);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones_in = 4'd0, tens_in = 4'd0;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int n = 0;
  logic [3:0] cap_t = 4'd0, cap_o = 4'd0;
  logic [6:0] seg_tab [16];

  bcd_display_mux #(.REFRESH_DIV(RD), .DEAD_CYCLES(DC), .TMR_W(4)) dut (
    .clk(clk), .reset(reset), .ones(ones_in), .tens(tens_in),
    .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg_t;
    logic [1:0] an_t;
    logic [6:0] seg_o;
  } vec_t;

  task automatic chk(input string name, input logic [6:0] es, input logic [1:0] ea, input logic ef);
    tests++;
    if (seg_n !== es || an_n !== ea || frame_done !== ef) begin
      fails++;
      $display("FAIL %s n=%0d: got seg_n=%h an_n=%b frame_done=%b, want seg_n=%h an_n=%b frame_done=%b",
               name, n, seg_n, an_n, frame_done, es, ea, ef);
    end
  endtask

  // Expected outputs from the position within the frame, counted in edges since reset release.
  task automatic model_chk(input string name);
    int ph;
    logic [6:0] es;
    logic [1:0] ea;
    logic ef;
    ph = n % FRAME;
    es = 7'h7F;
    ea = 2'b11;
    ef = (!reset && n > 0 && ph == 0);
    if (!reset && n > 0) begin
      if (ph >= DC && ph < DC + RD) begin
`ifdef LEADING_ZERO_BLANK_EN
        if (cap_t != 4'd0) begin
          es = seg_tab[cap_t];
          ea = 2'b10;
        end
`else
        es = seg_tab[cap_t];
        ea = 2'b10;
`endif
      end else if (ph >= 2 * DC + RD) begin
        es = seg_tab[cap_o];
        ea = 2'b01;
      end
    end
    chk(name, es, ea, ef);
  endtask

  task automatic step(input string name);
    @(posedge clk);
    if (!reset) begin
      n++;
      if (n % FRAME == DC) begin
        cap_t = tens_in;
        cap_o = ones_in;
      end
    end
    @(negedge clk);
    model_chk(name);
  endtask

  task automatic run_to(input int ph, input string name);
    int b;
    b = 0;
    while (n % FRAME != ph && b < 4 * FRAME) begin
      step(name);
      b++;
    end
    if (b >= 4 * FRAME) begin
      tests++;
      fails++;
      $display("FAIL run_to_%s: phase %0d not reached, got %0d", name, ph, n % FRAME);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tens_in = 4'($urandom);
      ones_in = 4'($urandom);
      step("reset_hold");
    end
    reset = 1'b0;
  endtask

  vec_t vecs [7];
  int cnt;

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    vecs[0] = '{4'd4, 4'd7, 7'h19, 2'b10, 7'h78};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[1] = '{4'd0, 4'd5, 7'h7F, 2'b11, 7'h12};
`else
    vecs[1] = '{4'd0, 4'd5, 7'h40, 2'b10, 7'h12};
`endif
    vecs[2] = '{4'hC, 4'hF, 7'h3F, 2'b10, 7'h3F};
    vecs[3] = '{4'd9, 4'd9, 7'h10, 2'b10, 7'h10};
    vecs[4] = '{4'd1, 4'd2, 7'h79, 2'b10, 7'h24};
    vecs[5] = '{4'd3, 4'd6, 7'h30, 2'b10, 7'h02};
    vecs[6] = '{4'd8, 4'hA, 7'h00, 2'b10, 7'h3F};

    @(negedge clk);
    do_reset(5);

    // Table vectors: inputs applied before the capture edge, both slots checked mid-slot.
    for (int v = 0; v < 7; v++) begin
      run_to(1, "tbl_pre");
      tens_in = vecs[v].tens;
      ones_in = vecs[v].ones;
      run_to(DC + 3, "tbl_t");
      chk($sformatf("tbl%0d_tens", v), vecs[v].seg_t, vecs[v].an_t, 1'b0);
      run_to(2 * DC + RD + 3, "tbl_o");
      chk($sformatf("tbl%0d_ones", v), vecs[v].seg_o, 2'b01, 1'b0);
      run_to(0, "tbl_end");
      chk($sformatf("tbl%0d_done", v), 7'h7F, 2'b11, 1'b1);
    end

    // Inputs changing during the tens slot must not tear the frame.
    run_to(1, "hold_pre");
    tens_in = 4'd4;
    ones_in = 4'd7;
    run_to(DC + 2, "hold_t");
    tens_in = 4'd9;
    ones_in = 4'd9;
    run_to(2 * DC + RD + 2, "hold_o");
    chk("hold_ones_old", 7'h78, 2'b01, 1'b0);
    run_to(DC + 2, "hold_next");
    chk("hold_next_tens", 7'h10, 2'b10, 1'b0);

    // Asynchronous reset mid ones slot.
    run_to(2 * DC + RD + 4, "rst_pre");
    #2 reset = 1'b1;
    n = 0;
    #1 chk("rst_async_blank", 7'h7F, 2'b11, 1'b0);
    @(negedge clk);
    do_reset(2);
    tens_in = 4'd2;
    ones_in = 4'd3;
    step("rst_rel1");
    chk("rst_rel1_blank", 7'h7F, 2'b11, 1'b0);
    step("rst_rel2");
    chk("rst_first_show", 7'h24, 2'b10, 1'b0);
    for (int i = 0; i < FRAME + 4; i++) step("rst_after");

    // Random inputs changing at random cycles, including non-BCD codes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        tens_in = 4'($urandom);
        ones_in = 4'($urandom);
      end
      step("rand");
    end

    // 00..99 counter advancing every cycle feeding the inputs.
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tens_in = 4'(cnt / 10);
      ones_in = 4'(cnt % 10);
      step("sweep");
      cnt = (cnt + 7) % 100;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
